alu_rs: RTL and testbench

//   Reservation station feeding the single-cycle integer ALU functional unit.
//   - Buffers renamed ALU ops from dispatch.
//   - Tracks per-source readiness.
//   - Wakes sources on CDB broadcasts.
//   - Issues one ready op per cycle over the valid/ready issue interface,

---
 rtl/alu_rs.sv | 197 +++++++++++++++++++
 tb/tb_alu_rs.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs -- reservation station in front of the single-cycle integer ALU.
//
// Holds renamed ALU ops from dispatch until both sources are available, then
// hands the lowest-index ready op to the FU over a valid/ready interface.
// Operand readiness is tracked per entry and woken by the FU's CDB broadcast.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   flush_i          squash every entry; beats dispatch, wakeup and issue
//   disp_valid_i     dispatch offers disp_pkt_i
//   disp_ready_o     a free entry exists (registered occupancy only)
//   disp_pkt_i       renamed op
//   disp_rs1_rdy_i   rs1 already in the PRF at dispatch
//   disp_rs2_rdy_i   rs2 already in the PRF at dispatch
//   cdb_valid_i      CDB broadcast valid
//   cdb_tag_i        physical tag being written back
//   issue_valid_o    some entry has both sources ready
//   issue_ready_i    FU accepts the offered op
//   issue_pkt_o      packet of the selected entry, '0 when none
//   occupancy_o      number of valid entries
// ---------------------------------------------------------------------------
package alu_rs_pkg;
    localparam int PREG_W  = 6;
    localparam int ROB_W   = 5;
    localparam int ALUOP_W = 4;
    localparam int XLEN    = 32;

    typedef struct packed {
        logic [PREG_W-1:0]  rs1_tag;
        logic [PREG_W-1:0]  rs2_tag;
        logic [PREG_W-1:0]  rd_tag;
        logic [ALUOP_W-1:0] alu_op;
        logic [XLEN-1:0]    imm;
        logic               imm_used;
        logic               rd_used;
        logic [ROB_W-1:0]   rob_tag;
    } issue_pkt_t;
endpackage

module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              disp_valid_i,
    output logic              disp_ready_o,
    input  issue_pkt_t        disp_pkt_i,
    input  logic              disp_rs1_rdy_i,
    input  logic              disp_rs2_rdy_i,
    input  logic              cdb_valid_i,
    input  logic [PREG_W-1:0] cdb_tag_i,
    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    output issue_pkt_t        issue_pkt_o,
    output logic [CNT_W-1:0]  occupancy_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage
    logic       r_valid   [DEPTH];
    issue_pkt_t r_pkt     [DEPTH];
    logic       r_rs1_rdy [DEPTH];
    logic       r_rs2_rdy [DEPTH];
    logic [CNT_W-1:0] r_occ;

    // Per-entry readiness (registered bits only, so a wakeup is issuable the
    // cycle after its broadcast).
    logic [DEPTH-1:0] w_entry_rdy;

    // Select / allocate results
    logic             w_sel_found;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;

    logic w_disp_fire;
    logic w_issue_fire;

    // Same-cycle wakeup bypass for the op being dispatched
    logic w_disp_rs1_rdy;
    logic w_disp_rs2_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_rdy
            // An immediate replaces rs2, so its tag is never waited on.
            assign w_entry_rdy[gi] = r_valid[gi] && r_rs1_rdy[gi]
                                     && (r_rs2_rdy[gi] || r_pkt[gi].imm_used);
        end
    endgenerate

    // Lowest-index ready entry. Scanning downwards lets the lowest hit win.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_entry_rdy[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // Lowest-index free entry.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    // Issue packet mux; zero when nothing is selectable.
    always_comb begin
        issue_pkt_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel_found && (w_sel_idx == IDX_W'(i))) begin
                issue_pkt_o = r_pkt[i];
            end
        end
    end

    assign issue_valid_o = w_sel_found;
    assign disp_ready_o  = (r_occ < CNT_W'(DEPTH));
    assign occupancy_o   = r_occ;

    // Flush squashes both handshakes in its cycle.
    assign w_disp_fire  = disp_valid_i && disp_ready_o && w_free_found && !flush_i;
    assign w_issue_fire = issue_valid_o && issue_ready_i && !flush_i;

    assign w_disp_rs1_rdy = disp_rs1_rdy_i
                            || (cdb_valid_i && (cdb_tag_i == disp_pkt_i.rs1_tag));
    assign w_disp_rs2_rdy = disp_rs2_rdy_i
                            || (cdb_valid_i && (cdb_tag_i == disp_pkt_i.rs2_tag));

    // Per-entry state. Dispatch only targets an invalid entry and issue only a
    // valid one, so the two never hit the same slot in one cycle.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic w_alloc_here;
            logic w_issue_here;

            assign w_alloc_here = w_disp_fire && (w_free_idx == IDX_W'(gi));
            assign w_issue_here = w_issue_fire && (w_sel_idx == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[gi]   <= 1'b0;
                    r_pkt[gi]     <= '0;
                    r_rs1_rdy[gi] <= 1'b0;
                    r_rs2_rdy[gi] <= 1'b0;
                end else if (flush_i) begin
                    r_valid[gi]   <= 1'b0;
                    r_rs1_rdy[gi] <= 1'b0;
                    r_rs2_rdy[gi] <= 1'b0;
                end else if (w_alloc_here) begin
                    r_valid[gi]   <= 1'b1;
                    r_pkt[gi]     <= disp_pkt_i;
                    r_rs1_rdy[gi] <= w_disp_rs1_rdy;
                    r_rs2_rdy[gi] <= w_disp_rs2_rdy;
                end else if (w_issue_here) begin
                    r_valid[gi]   <= 1'b0;
                end else if (r_valid[gi] && cdb_valid_i) begin
                    if (cdb_tag_i == r_pkt[gi].rs1_tag) begin
                        r_rs1_rdy[gi] <= 1'b1;
                    end
                    if (cdb_tag_i == r_pkt[gi].rs2_tag) begin
                        r_rs2_rdy[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Occupancy counter; simultaneous dispatch and issue cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush_i) begin
            r_occ <= '0;
        end else if (w_disp_fire && !w_issue_fire) begin
            r_occ <= r_occ + CNT_W'(1);
        end else if (w_issue_fire && !w_disp_fire) begin
            r_occ <= r_occ - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs -- directed, table-driven bench for alu_rs (DEPTH = 8).
// Inputs change on the falling edge; outputs are checked 1ns later, so every
// check sees the state left by the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush_i = 1'b0;
    logic              disp_valid_i = 1'b0;
    logic              disp_ready_o;
    issue_pkt_t        disp_pkt_i = '0;
    logic              disp_rs1_rdy_i = 1'b0;
    logic              disp_rs2_rdy_i = 1'b0;
    logic              cdb_valid_i = 1'b0;
    logic [PREG_W-1:0] cdb_tag_i = '0;
    logic              issue_valid_o;
    logic              issue_ready_i = 1'b0;
    issue_pkt_t        issue_pkt_o;
    logic [CNT_W-1:0]  occupancy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_rs #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .disp_valid_i   (disp_valid_i),
        .disp_ready_o   (disp_ready_o),
        .disp_pkt_i     (disp_pkt_i),
        .disp_rs1_rdy_i (disp_rs1_rdy_i),
        .disp_rs2_rdy_i (disp_rs2_rdy_i),
        .cdb_valid_i    (cdb_valid_i),
        .cdb_tag_i      (cdb_tag_i),
        .issue_valid_o  (issue_valid_o),
        .issue_ready_i  (issue_ready_i),
        .issue_pkt_o    (issue_pkt_o),
        .occupancy_o    (occupancy_o)
    );

    typedef struct {
        logic       flush;
        logic       dv;
        logic [5:0] rs1;
        logic [5:0] rs2;
        logic [4:0] rob;
        logic       imm_u;
        logic       r1r;
        logic       r2r;
        logic       cv;
        logic [5:0] ct;
        logic       ir;
        logic       e_iv;
        logic [4:0] e_rob;
        logic       e_dr;
        logic [3:0] e_occ;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic issue_pkt_t mkpkt(input logic [5:0] rs1, input logic [5:0] rs2,
                                         input logic [4:0] rob, input logic imm_u);
        issue_pkt_t p;
        p          = '0;
        p.rs1_tag  = rs1;
        p.rs2_tag  = rs2;
        p.rd_tag   = {1'b1, rob};
        p.alu_op   = rob[3:0];
        p.imm      = {27'h5A5A5A5, rob};
        p.imm_used = imm_u;
        p.rd_used  = 1'b1;
        p.rob_tag  = rob;
        return p;
    endfunction

    function automatic vec_t v(input logic flush, input logic dv, input logic [5:0] rs1,
                               input logic [5:0] rs2, input logic [4:0] rob,
                               input logic imm_u, input logic r1r, input logic r2r,
                               input logic cv, input logic [5:0] ct, input logic ir,
                               input logic e_iv, input logic [4:0] e_rob,
                               input logic e_dr, input logic [3:0] e_occ);
        vec_t t;
        t.flush = flush; t.dv = dv; t.rs1 = rs1; t.rs2 = rs2; t.rob = rob;
        t.imm_u = imm_u; t.r1r = r1r; t.r2r = r2r; t.cv = cv; t.ct = ct; t.ir = ir;
        t.e_iv = e_iv; t.e_rob = e_rob; t.e_dr = e_dr; t.e_occ = e_occ;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic flush, input logic dv, input issue_pkt_t p,
                         input logic r1r, input logic r2r, input logic cv,
                         input logic [5:0] ct, input logic ir);
        flush_i        = flush;
        disp_valid_i   = dv;
        disp_pkt_i     = p;
        disp_rs1_rdy_i = r1r;
        disp_rs2_rdy_i = r2r;
        cdb_valid_i    = cv;
        cdb_tag_i      = ct;
        issue_ready_i  = ir;
    endtask

    task automatic idle(input logic ir);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, ir);
    endtask

    // Checks the issue side: rob tag when valid, an all-zero packet otherwise.
    task automatic check_out(input string tag, input logic e_iv, input logic [4:0] e_rob,
                             input logic e_dr, input logic [3:0] e_occ);
        check({tag, ".issue_valid"}, 64'(issue_valid_o), 64'(e_iv));
        if (e_iv)
            check({tag, ".rob_tag"}, 64'(issue_pkt_o.rob_tag), 64'(e_rob));
        else
            check({tag, ".pkt_zero"}, 64'(issue_pkt_o), 64'(0));
        check({tag, ".disp_ready"}, 64'(disp_ready_o), 64'(e_dr));
        check({tag, ".occupancy"}, 64'(occupancy_o), 64'(e_occ));
        $display("%s: iv=%0d rob=%0d dr=%0d occ=%0d", tag, issue_valid_o,
                 issue_pkt_o.rob_tag, disp_ready_o, occupancy_o);
    endtask

    initial begin
        //            fl dv rs1 rs2 rob imm r1 r2 cv ct  ir | iv rob dr occ
        // 1: ready op issues the cycle after dispatch
        vecs[0]  = v(0, 1,  1,  2,  3, 0, 1, 1, 0,  0, 0,  0, 0, 1, 0);
        vecs[1]  = v(0, 0,  0,  0,  0, 0, 0, 0, 0,  0, 1,  1, 3, 1, 1);
        vecs[2]  = v(0, 0,  0,  0,  0, 0, 0, 0, 0,  0, 1,  0, 0, 1, 0);
        // 2: rs1 tag 12 woken two cycles after dispatch
        vecs[3]  = v(0, 1, 12,  1,  4, 0, 0, 1, 0,  0, 1,  0, 0, 1, 0);
        vecs[4]  = v(0, 0,  0,  0,  0, 0, 0, 0, 0,  0, 1,  0, 0, 1, 1);
        vecs[5]  = v(0, 0,  0,  0,  0, 0, 0, 0, 1, 12, 1,  0, 0, 1, 1);
        vecs[6]  = v(0, 0,  0,  0,  0, 0, 0, 0, 0,  0, 1,  1, 4, 1, 1);
        vecs[7]  = v(0, 0,  0,  0,  0, 0, 0, 0, 0,  0, 1,  0, 0, 1, 0);
        // 3: rs2 tag 7 broadcast in the dispatch cycle (bypass)
        vecs[8]  = v(0, 1,  2,  7,  5, 0, 1, 0, 1,  7, 1,  0, 0, 1, 0);
        vecs[9]  = v(0, 0,  0,  0,  0, 0, 0, 0, 0,  0, 1,  1, 5, 1, 1);
        // immediate op: rs2 not ready but ignored; held (ir=0)
        vecs[10] = v(0, 1,  3,  9,  6, 1, 1, 0, 0,  0, 0,  0, 0, 1, 0);
        // 6: three more non-ready entries, then flush with a dispatch offered
        vecs[11] = v(0, 1, 20, 21,  7, 0, 0, 0, 0,  0, 0,  1, 6, 1, 1);
        vecs[12] = v(0, 1, 22, 23,  8, 0, 0, 0, 0,  0, 0,  1, 6, 1, 2);
        vecs[13] = v(0, 1, 24, 25,  9, 0, 0, 0, 0,  0, 0,  1, 6, 1, 3);
        vecs[14] = v(1, 1,  4,  5, 10, 0, 1, 1, 0,  0, 1,  1, 6, 1, 4);
        vecs[15] = v(0, 0,  0,  0,  0, 0, 0, 0, 0,  0, 1,  0, 0, 1, 0);
        vecs[16] = v(0, 0,  0,  0,  0, 0, 0, 0, 0,  0, 1,  0, 0, 1, 0);

        // Reset state
        #2;
        check_out("reset_async", 1'b0, 5'd0, 1'b1, 4'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven section
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].flush, vecs[i].dv,
                  mkpkt(vecs[i].rs1, vecs[i].rs2, vecs[i].rob, vecs[i].imm_u),
                  vecs[i].r1r, vecs[i].r2r, vecs[i].cv, vecs[i].ct, vecs[i].ir);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].e_iv, vecs[i].e_rob,
                      vecs[i].e_dr, vecs[i].e_occ);
        end

        // 4: fill all entries, none ready
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, mkpkt(6'(30 + i), 6'd0, 5'(10 + i), 1'b0),
                  1'b0, 1'b1, 1'b0, '0, 1'b1);
            #1;
            check_out($sformatf("fill%0d", i), 1'b0, 5'd0, 1'b1, 4'(i));
        end
        // full: offered ready op must be refused
        @(negedge clk);
        drive(1'b0, 1'b1, mkpkt(6'd1, 6'd2, 5'd31, 1'b0), 1'b1, 1'b1, 1'b0, '0, 1'b1);
        #1;
        check_out("full", 1'b0, 5'd0, 1'b0, 4'd8);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 6'd35, 1'b1);
        #1;
        check_out("full_wake5", 1'b0, 5'd0, 1'b0, 4'd8);
        @(negedge clk);
        idle(1'b1);
        #1;
        check_out("issue_e5", 1'b1, 5'd15, 1'b0, 4'd8);
        @(negedge clk);
        drive(1'b0, 1'b1, mkpkt(6'd1, 6'd2, 5'd20, 1'b0), 1'b1, 1'b1, 1'b0, '0, 1'b0);
        #1;
        check_out("slot_free", 1'b0, 5'd0, 1'b1, 4'd7);
        // new op sits in slot 5: waking entry 6 leaves it selected, entry 4 wins
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 6'd36, 1'b0);
        #1;
        check_out("refill5", 1'b1, 5'd20, 1'b0, 4'd8);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 6'd34, 1'b0);
        #1;
        check_out("slot5_vs_6", 1'b1, 5'd20, 1'b0, 4'd8);
        @(negedge clk);
        idle(1'b0);
        #1;
        check_out("slot4_wins", 1'b1, 5'd14, 1'b0, 4'd8);
        @(negedge clk);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        check_out("flush2", 1'b1, 5'd14, 1'b0, 4'd8);
        @(negedge clk);
        idle(1'b0);
        #1;
        check_out("post_flush2", 1'b0, 5'd0, 1'b1, 4'd0);

        // 5: entries 2 and 6 ready, issue stalled for 3 cycles
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, mkpkt(6'(40 + i), 6'd0, 5'(16 + i), 1'b0),
                  (i == 2 || i == 6), 1'b1, 1'b0, '0, 1'b0);
            #1;
            check($sformatf("load%0d.occupancy", i), 64'(occupancy_o), 64'(i));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle(1'b0);
            #1;
            check_out($sformatf("stall%0d", i), 1'b1, 5'd18, 1'b1, 4'd7);
        end
        @(negedge clk);
        idle(1'b1);
        #1;
        check_out("drain_e2", 1'b1, 5'd18, 1'b1, 4'd7);
        @(negedge clk);
        #1;
        check_out("drain_e6", 1'b1, 5'd22, 1'b1, 4'd6);
        @(negedge clk);
        idle(1'b0);
        #1;
        check_out("drained", 1'b0, 5'd0, 1'b1, 4'd5);

        // Asynchronous reset mid-operation, away from the clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_mid", 1'b0, 5'd0, 1'b1, 4'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_out("after_rst", 1'b0, 5'd0, 1'b1, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
